// File: rtl/dmem_responder.sv
// dmem_responder
// ---------------------------------------------------------------------------
// Data-memory responder for the dual-issue memory stage. It accepts one
// two-lane load/store bundle, services lane 0 and then lane 1 against an
// internal word-addressed RAM, and returns a single two-lane response that the
// commit side always consumes.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   req_valid    [1:0]        per-lane request valid (bit i = lane i)
//   req_ready    out          high only in IDLE and not in reset
//   req_we       [1:0]        per-lane store(1)/load(0)
//   req_addr     [2*ADDR_W]   lane i byte address at [i*ADDR_W +: ADDR_W]
//   req_wdata    [63:0]       lane i store data at [i*32 +: 32]
//   req_be       [7:0]        lane i byte enables at [i*4 +: 4]
//   resp_valid   [1:0]        per-lane response, high for the single RESP cycle
//   resp_rdata   [63:0]       lane i load data; holds its value outside RESP
//   resp_err     [1:0]        per-lane error; holds its value outside RESP
//   dbg_state    [1:0]        current FSM state (IDLE=0, ACC0=1, ACC1=2, RESP=3)
//   mmio_out     [7:0]        only when DMEM_MMIO_EN is defined
//
// Handshake: a bundle is taken at a rising edge where req_ready && |req_valid.
// All request fields are sampled at that edge only. There is no response
// backpressure.
//
// Optional feature (macro DMEM_MMIO_EN): addresses with addr[31:28]==4'hF map
// to an 8-bit output register instead of the RAM and are never out of range.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  input  logic [7:0]          req_be,
  output logic [1:0]          resp_valid,
  output logic [63:0]         resp_rdata,
  output logic [1:0]          resp_err,
  output logic [1:0]          dbg_state
`ifdef DMEM_MMIO_EN
  ,
  output logic [7:0]          mmio_out
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]          cap_valid;
  logic [1:0]          cap_we;
  logic [2*ADDR_W-1:0] cap_addr;
  logic [63:0]         cap_wdata;
  logic [7:0]          cap_be;
  logic [31:0]         res0_rdata;
  logic                res0_err;

  // Lane currently being serviced (only meaningful in ACC0/ACC1).
  logic              lane;
  logic [ADDR_W-1:0] lane_addr;
  logic [31:0]       lane_wdata;
  logic [3:0]        lane_be;
  logic              lane_we;
  logic              lane_err;
  logic              out_of_range;
  logic              is_mmio;
  logic [31:0]       load_word;
  logic [31:0]       lane_rdata;
  logic [IDX_W-1:0]  idx;
  logic              do_access;
  logic              ram_we;
  logic              accept;
  logic [31:0]       l0_rdata, l1_rdata;
  logic              l0_err, l1_err;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_ready && (|req_valid);
  assign dbg_state = state;
  assign resp_valid = (state == RESP) ? cap_valid : 2'b00;

  always_comb begin
    lane       = (state == ACC1);
    lane_addr  = lane ? cap_addr[ADDR_W +: ADDR_W] : cap_addr[0 +: ADDR_W];
    lane_wdata = lane ? cap_wdata[32 +: 32]       : cap_wdata[0 +: 32];
    lane_be    = lane ? cap_be[4 +: 4]            : cap_be[0 +: 4];
    lane_we    = lane ? cap_we[1]                 : cap_we[0];
    idx        = lane_addr[2 +: IDX_W];
    out_of_range = lane_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS);
`ifdef DMEM_MMIO_EN
    is_mmio = (lane_addr[ADDR_W-1 -: 4] == 4'hF);
`else
    is_mmio = 1'b0;
`endif
    lane_err = (|lane_addr[1:0]) || (!is_mmio && out_of_range);
    // Guarded read keeps the index inside the array for non-power-of-2 depths.
    load_word = out_of_range ? 32'h0 : mem[idx];
`ifdef DMEM_MMIO_EN
    if (is_mmio) load_word = {24'h0, mmio_out};
`endif
    // Stores and faulting accesses return zero data.
    lane_rdata = (lane_we || lane_err) ? 32'h0 : load_word;
    do_access  = (state == ACC0) || (state == ACC1);
    ram_we     = do_access && lane_we && !lane_err && !is_mmio;
  end

  // Assemble the response on the edge that enters RESP: lane 0 comes from the
  // held ACC0 result unless lane 0 is being serviced right now.
  always_comb begin
    l0_rdata = (state == ACC0) ? lane_rdata : res0_rdata;
    l0_err   = (state == ACC0) ? lane_err   : res0_err;
    l1_rdata = (state == ACC1) ? lane_rdata : 32'h0;
    l1_err   = (state == ACC1) ? lane_err   : 1'b0;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = req_valid[0] ? ACC0 : ACC1;
      ACC0: state_next = cap_valid[1] ? ACC1 : RESP;
      ACC1: state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_valid  <= 2'b00;
      cap_we     <= 2'b00;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_be     <= '0;
      res0_rdata <= '0;
      res0_err   <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'b00;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_valid  <= req_valid;
        cap_we     <= req_we;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        cap_be     <= req_be;
        // An invalid lane 0 must report zero data and no error.
        res0_rdata <= '0;
        res0_err   <= 1'b0;
      end
      if (state == ACC0) begin
        res0_rdata <= lane_rdata;
        res0_err   <= lane_err;
      end
      if (do_access && state_next == RESP) begin
        resp_rdata <= {l1_rdata, l0_rdata};
        resp_err   <= {l1_err, l0_err};
      end
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_out <= 8'h00;
    end else if (do_access && is_mmio && lane_we && !lane_err && lane_be[0]) begin
      mmio_out <= lane_wdata[7:0];
    end
  end
`endif

  // RAM has no reset; a store finished before a reset stays in place.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[idx][b*8 +: 8] <= lane_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic        req_ready;
  logic [1:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [1:0]  resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [1:0]  dbg_state;
`ifdef DMEM_MMIO_EN
  logic [7:0]  mmio_out;
`endif

  int tests;
  int fails;
  int cyc;

  // Expected response entries: {valid[1:0], err[1:0], rdata_lane1, rdata_lane0}
  logic [67:0] exp_q[$];
  int          cyc_q[$];

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .dbg_state(dbg_state)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_out(mmio_out)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [67:0] e;
    int          ec;
    if (!rst && resp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp got valid=%b err=%b rdata=%h exp none", resp_valid, resp_err, resp_rdata);
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("resp_bundle", {resp_valid, resp_err, resp_rdata}, e);
        chk("resp_latency", 68'(cyc), 68'(ec));
      end
    end
  end

  // Driver: present a bundle at a negedge, wait for acceptance, then scramble
  // the inputs so any late sampling shows up.
  task automatic send(input logic [1:0] v, input logic [1:0] we,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] b0, input logic [3:0] b1,
                      input bit expect_resp, input logic [1:0] ev, input logic [1:0] ee,
                      input logic [31:0] r0, input logic [31:0] r1);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    req_be    = {b1, b0};
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got ready=0 exp ready=1");
    end else begin
      @(posedge clk);
      #1;
      if (expect_resp) begin
        exp_q.push_back({ev, ee, r1, r0});
        cyc_q.push_back(cyc + ((v == 2'b11) ? 2 : 1));
      end
    end
    req_valid = 2'b00;
    req_we    = 2'b11;
    req_addr  = '1;
    req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    req_be    = 8'hFF;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 68'(exp_q.size()), 68'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready_low", 68'(req_ready), 68'd0);
    rst = 1'b0;
    #1;
    chk("reset_ready", 68'(req_ready), 68'd1);
    chk("reset_state", 68'(dbg_state), 68'd0);
    chk("reset_resp", {resp_valid, resp_err, resp_rdata}, 68'd0);

    // Reset in ACC0: bundle discarded, no response.
    send(2'b11, 2'b01, 32'h20, 32'h24, 32'h1234_5678, 32'h0, 4'hF, 4'h0, 0, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    chk("acc0_state", 68'(dbg_state), 68'd1);
    rst = 1'b1;
    #1;
    chk("midrst_state", 68'(dbg_state), 68'd0);
    chk("midrst_ready", 68'(req_ready), 68'd0);
    chk("midrst_valid", 68'(resp_valid), 68'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_ready", 68'(req_ready), 68'd1);
    chk("postrst_state", 68'(dbg_state), 68'd0);
    repeat (4) @(negedge clk);

    // Reset in ACC1: lane-0 store already done must persist.
    send(2'b11, 2'b01, 32'h10, 32'h14, 32'hAABB_CCDD, 32'h0, 4'hF, 4'h0, 0, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("acc1_state", 68'(dbg_state), 68'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(2'b01, 2'b00, 32'h10, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b00, 32'hAABB_CCDD, 0);
    drain();

    // Dual bundle: store then same-word load, with ready/hold checks.
    send(2'b11, 2'b01, 32'h100, 32'h100, 32'h1122_3344, 32'h0, 4'hF, 4'hF, 1, 2'b11, 2'b00, 0, 32'h1122_3344);
    @(negedge clk);
    chk("ready_acc0", 68'(req_ready), 68'd0);
    @(negedge clk);
    chk("ready_acc1", 68'(req_ready), 68'd0);
    @(negedge clk);
    chk("ready_resp", 68'(req_ready), 68'd0);
    @(negedge clk);
    chk("ready_after", 68'(req_ready), 68'd1);
    chk("valid_after", 68'(resp_valid), 68'd0);
    chk("rdata_hold", 68'(resp_rdata), 68'h1122_3344_0000_0000);

    // Partial store
    send(2'b01, 2'b01, 32'h40, 32'h0, 32'hFFFF_FFFF, 0, 4'hF, 4'h0, 1, 2'b01, 2'b00, 0, 0);
    send(2'b01, 2'b01, 32'h40, 32'h0, 32'h0000_00AB, 0, 4'b0001, 4'h0, 1, 2'b01, 2'b00, 0, 0);
    send(2'b01, 2'b00, 32'h40, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b00, 32'hFFFF_FFAB, 0);

    // Errors: misaligned load, out-of-range store, misaligned store suppressed.
    send(2'b01, 2'b00, 32'h102, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b01, 0, 0);
    send(2'b01, 2'b01, 32'h0, 32'h0, 32'h0102_0304, 0, 4'hF, 4'h0, 1, 2'b01, 2'b00, 0, 0);
    send(2'b01, 2'b01, 32'd4096, 32'h0, 32'hDEAD_BEEF, 0, 4'hF, 4'h0, 1, 2'b01, 2'b01, 0, 0);
    send(2'b01, 2'b00, 32'h0, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b00, 32'h0102_0304, 0);
    send(2'b11, 2'b01, 32'h42, 32'h40, 32'h0, 0, 4'hF, 4'h0, 1, 2'b11, 2'b01, 0, 32'hFFFF_FFAB);

    // Single lane 1
    send(2'b10, 2'b00, 32'h0, 32'h100, 0, 0, 4'h0, 4'h0, 1, 2'b10, 2'b00, 0, 32'h1122_3344);

    // Overlapping stores: lane 1 wins on shared bytes; be=0 store is a no-op.
    send(2'b11, 2'b11, 32'h80, 32'h80, 32'h1111_1111, 32'h2222_2222, 4'hF, 4'b0011, 1, 2'b11, 2'b00, 0, 0);
    send(2'b11, 2'b01, 32'h80, 32'h80, 32'h0, 0, 4'h0, 4'h0, 1, 2'b11, 2'b00, 0, 32'h1111_2222);

`ifdef DMEM_MMIO_EN
    send(2'b01, 2'b01, 32'hF000_0000, 32'h0, 32'h0000_005A, 0, 4'b0001, 4'h0, 1, 2'b01, 2'b00, 0, 0);
    drain();
    chk("mmio_out", 68'(mmio_out), 68'h5A);
    send(2'b01, 2'b00, 32'hF000_0000, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b00, 32'h0000_005A, 0);
`else
    send(2'b01, 2'b00, 32'hF000_0000, 32'h0, 0, 0, 4'h0, 4'h0, 1, 2'b01, 2'b01, 0, 0);
`endif

    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
